// File: rtl/xtl_clk_monitor.sv
// xtl_clk_monitor
//   Crystal oscillator frequency monitor and clock-source sequencer. Counts
//   rising edges of the asynchronous crystal over fixed windows of CLK cycles.
//   It selects the crystal only after LOCK_WINDOWS consecutive in-range
//   windows, and drops back to the RC oscillator on the first bad window
//   while locked.
//
//   Build option: define XTL_MON_AUTO_RETRY_EN so that FAULT re-enters
//   ACQUIRE on its own after RETRY_WINDOWS windows. Without it, FAULT is
//   left only through CLR_FAIL.
//
// Ports
//   CLK         RC oscillator fabric clock
//   RESET       synchronous, active-high reset
//   ENABLE      monitor enable; low forces IDLE
//   XTLOSC_IN   crystal output, asynchronous to CLK
//   CLR_FAIL    single-cycle pulse that clears XTL_FAIL
//   SEL_XTL     1 = crystal, 0 = RC oscillator (glitch-free mux select)
//   XTL_GOOD    last completed window was in range
//   XTL_FAIL    sticky: a locked crystal went out of range
//   MEAS_VALID  one-cycle pulse when EDGE_COUNT updates
//   EDGE_COUNT  edge count of the last completed window
module xtl_clk_monitor #(
  parameter int unsigned WINDOW_CYCLES = 50000,
  parameter int unsigned CNT_MIN       = 9900,
  parameter int unsigned CNT_MAX       = 10100,
  parameter int unsigned LOCK_WINDOWS  = 4,
  parameter int unsigned RETRY_WINDOWS = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic        XTLOSC_IN,
  input  logic        CLR_FAIL,
  output logic        SEL_XTL,
  output logic        XTL_GOOD,
  output logic        XTL_FAIL,
  output logic        MEAS_VALID,
  output logic [15:0] EDGE_COUNT
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED,
    ST_FAULT
  } state_t;

  localparam logic [15:0] WCNT_LAST = 16'(WINDOW_CYCLES - 1);
  localparam logic [15:0] CNT_MIN_C = 16'(CNT_MIN);
  localparam logic [15:0] CNT_MAX_C = 16'(CNT_MAX);
  localparam logic [3:0]  LOCK_C    = 4'(LOCK_WINDOWS);

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        hist_q, hist_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [15:0] ecnt_q, ecnt_d;
  logic [15:0] edge_count_q, edge_count_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        sel_q, sel_d;
  logic        good_q, good_d;
  logic        fail_q, fail_d;
  logic        meas_q, meas_d;
`ifdef XTL_MON_AUTO_RETRY_EN
  localparam logic [7:0] RETRY_C = 8'(RETRY_WINDOWS);
  logic [7:0]  retry_q, retry_d;
`endif

  logic        xtl_edge;
  logic        term;
  logic        win_ok;
  logic [15:0] total;

  // Parameter legality, checked in simulation only.
  always_ff @(posedge CLK) begin
    assert (WINDOW_CYCLES >= 16 && WINDOW_CYCLES <= 65535 &&
            LOCK_WINDOWS >= 1 && LOCK_WINDOWS <= 15 &&
            RETRY_WINDOWS >= 1 && RETRY_WINDOWS <= 255 &&
            CNT_MIN <= CNT_MAX);
  end

  always_comb begin
    sync1_d = XTLOSC_IN;
    sync2_d = sync1_q;
    hist_d  = sync2_q;

    xtl_edge = sync2_q & ~hist_q;
    term     = (wcnt_q == WCNT_LAST);
    // Saturating accumulate; on the terminal cycle this is the window result.
    total    = (ecnt_q == 16'hFFFF) ? 16'hFFFF : ecnt_q + {15'd0, xtl_edge};
    win_ok   = (total >= CNT_MIN_C) && (total <= CNT_MAX_C);

    state_d      = state_q;
    wcnt_d       = wcnt_q;
    ecnt_d       = ecnt_q;
    edge_count_d = edge_count_q;
    good_cnt_d   = good_cnt_q;
    good_d       = good_q;
    fail_d       = fail_q;
    meas_d       = 1'b0;
`ifdef XTL_MON_AUTO_RETRY_EN
    retry_d      = retry_q;
`endif

    if (CLR_FAIL) begin
      fail_d = 1'b0;
    end

    if (!ENABLE) begin
      state_d    = ST_IDLE;
      wcnt_d     = '0;
      ecnt_d     = '0;
      good_cnt_d = '0;
`ifdef XTL_MON_AUTO_RETRY_EN
      retry_d    = '0;
`endif
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_ACQUIRE;
      wcnt_d     = '0;
      ecnt_d     = '0;
      good_cnt_d = '0;
    end else begin
      if (term) begin
        wcnt_d       = '0;
        ecnt_d       = '0;
        meas_d       = 1'b1;
        edge_count_d = total;
        good_d       = win_ok;
      end else begin
        wcnt_d = wcnt_q + 16'd1;
        ecnt_d = total;
      end

      case (state_q)
        ST_ACQUIRE: begin
          if (term) begin
            if (!win_ok) begin
              good_cnt_d = '0;
            end else if (4'(good_cnt_q + 4'd1) == LOCK_C) begin
              good_cnt_d = '0;
              state_d    = ST_LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 4'd1;
            end
          end
        end
        ST_LOCKED: begin
          // Set overrides a same-cycle CLR_FAIL.
          if (term && !win_ok) begin
            fail_d  = 1'b1;
            state_d = ST_FAULT;
          end
        end
        ST_FAULT: begin
`ifdef XTL_MON_AUTO_RETRY_EN
          if (term) begin
            if (8'(retry_q + 8'd1) == RETRY_C) begin
              retry_d    = '0;
              good_cnt_d = '0;
              state_d    = ST_ACQUIRE;
            end else begin
              retry_d = retry_q + 8'd1;
            end
          end
`else
          if (CLR_FAIL) begin
            good_cnt_d = '0;
            state_d    = ST_ACQUIRE;
          end
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Registered select follows the next state so it moves with the FSM.
    sel_d = (state_d == ST_LOCKED);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      wcnt_q       <= '0;
      ecnt_q       <= '0;
      edge_count_q <= '0;
      good_cnt_q   <= '0;
      sel_q        <= 1'b0;
      good_q       <= 1'b0;
      fail_q       <= 1'b0;
      meas_q       <= 1'b0;
`ifdef XTL_MON_AUTO_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      wcnt_q       <= wcnt_d;
      ecnt_q       <= ecnt_d;
      edge_count_q <= edge_count_d;
      good_cnt_q   <= good_cnt_d;
      sel_q        <= sel_d;
      good_q       <= good_d;
      fail_q       <= fail_d;
      meas_q       <= meas_d;
`ifdef XTL_MON_AUTO_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  assign SEL_XTL    = sel_q;
  assign XTL_GOOD   = good_q;
  assign XTL_FAIL   = fail_q;
  assign MEAS_VALID = meas_q;
  assign EDGE_COUNT = edge_count_q;

endmodule

// File: tb/tb_xtl_clk_monitor.sv
// Testbench for xtl_clk_monitor. A window-level reference model keeps the
// sampled crystal history, counts rising edges over each completed window by
// summation, and applies the lock / fault / retry rules; expected window
// results go into a scoreboard queue that a separate monitor drains on
// MEAS_VALID.
module tb_xtl_clk_monitor;

  localparam int W      = 100;
  localparam int CMIN   = 9;
  localparam int CMAX   = 11;
  localparam int LOCKN  = 2;
  localparam int RETRYN = 3;
  localparam int NMAX   = 24000;

  logic        CLK, RESET, ENABLE, XTLOSC_IN, CLR_FAIL;
  logic        SEL_XTL, XTL_GOOD, XTL_FAIL, MEAS_VALID;
  logic [15:0] EDGE_COUNT;

  xtl_clk_monitor #(
    .WINDOW_CYCLES(W),
    .CNT_MIN(CMIN),
    .CNT_MAX(CMAX),
    .LOCK_WINDOWS(LOCKN),
    .RETRY_WINDOWS(RETRYN)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .ENABLE(ENABLE),
    .XTLOSC_IN(XTLOSC_IN),
    .CLR_FAIL(CLR_FAIL),
    .SEL_XTL(SEL_XTL),
    .XTL_GOOD(XTL_GOOD),
    .XTL_FAIL(XTL_FAIL),
    .MEAS_VALID(MEAS_VALID),
    .EDGE_COUNT(EDGE_COUNT)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [16:0] exp_q[$];  // {good, count}

  bit          m_sel, m_fail, m_good;
  logic [15:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0d, required %0d", name, $time, act, req);
    end
  endtask

  // CLK period 10; posedges at 5 + 10k.
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Crystal: toggles at 2 + 5m only, never on a CLK edge. Period = xk CLK cycles.
  int xk    = 10;
  bit xstop = 1'b0;
  initial begin
    XTLOSC_IN = 1'b0;
    #2;
    forever begin
      #(5 * xk);
      if (!xstop) XTLOSC_IN = ~XTLOSC_IN;
    end
  end

  // Reference model, evaluated at each CLK rising edge.
  bit xin  [0:NMAX];
  bit attr [0:NMAX];
  initial begin
    int t, start, streak, retry, c;
    bit running, locked, faulted, was_faulted, ok, fail_n;
    t = 0; start = 0; streak = 0; retry = 0;
    running = 0; locked = 0; faulted = 0;
    m_sel = 0; m_fail = 0; m_good = 0; m_count = '0;
    forever begin
      @(posedge CLK);
      t++;
      if (t >= NMAX) begin
        $display("FAIL model_budget: t=%0d, required < %0d", t, NMAX);
        $fatal(1, "model history exhausted");
      end
      xin[t]  = XTLOSC_IN;
      // An edge first sampled at cycle n is accounted at cycle n+2.
      attr[t] = (t >= 3) && xin[t-2] && !xin[t-3];
      if (RESET) begin
        xin[t] = 0; xin[t-1] = 0;
        if (t >= 2) xin[t-2] = 0;
        running = 0; locked = 0; faulted = 0; streak = 0; retry = 0;
        m_sel = 0; m_fail = 0; m_good = 0; m_count = '0;
        exp_q.delete();
      end else begin
        fail_n = m_fail;
        if (CLR_FAIL) fail_n = 0;
        if (!ENABLE) begin
          running = 0; locked = 0; faulted = 0; streak = 0; retry = 0;
        end else if (!running) begin
          running = 1; start = t; streak = 0;
        end else begin
          was_faulted = faulted;
          if ((t - start) % W == 0) begin
            c = 0;
            for (int i = t - W + 1; i <= t; i++) c += int'(attr[i]);
            if (c > 65535) c = 65535;
            ok = (c >= CMIN) && (c <= CMAX);
            exp_q.push_back({ok, 16'(c)});
            m_count = 16'(c);
            m_good  = ok;
            if (faulted) begin
`ifdef XTL_MON_AUTO_RETRY_EN
              retry++;
              if (retry == RETRYN) begin
                faulted = 0; retry = 0; streak = 0;
              end
`endif
            end else if (locked) begin
              if (!ok) begin
                locked = 0; faulted = 1; fail_n = 1;
              end
            end else begin
              streak = ok ? streak + 1 : 0;
              if (streak == LOCKN) begin
                locked = 1; streak = 0;
              end
            end
          end
`ifndef XTL_MON_AUTO_RETRY_EN
          if (was_faulted && CLR_FAIL) begin
            faulted = 0; streak = 0;
          end
`endif
        end
        m_fail = fail_n;
        m_sel  = locked;
      end
    end
  end

  // Monitor: sampled on the falling edge, away from DUT updates.
  initial begin
    logic [16:0] e;
    bit exp_meas;
    forever begin
      @(negedge CLK);
      exp_meas = (exp_q.size() != 0);
      check("meas_valid", MEAS_VALID, exp_meas);
      if (exp_meas) begin
        e = exp_q.pop_front();
        if (MEAS_VALID === 1'b1) begin
          check("window_count", EDGE_COUNT, e[15:0]);
          check("window_good", XTL_GOOD, e[16]);
        end
      end
      check("sel_xtl", SEL_XTL, m_sel);
      check("xtl_fail", XTL_FAIL, m_fail);
      check("xtl_good", XTL_GOOD, m_good);
      check("edge_count", EDGE_COUNT, m_count);
    end
  end

  task automatic wait_sel(input int budget, input string name);
    int n = 0;
    while (SEL_XTL !== 1'b1 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    n_cmp++;
    if (SEL_XTL !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: SEL_XTL=%b after %0d cycles, required 1", name, SEL_XTL, n);
    end
  endtask

  task automatic wait_meas(input int budget, input string name);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (MEAS_VALID !== 1'b1 && n < budget);
    n_cmp++;
    if (MEAS_VALID !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: no MEAS_VALID in %0d cycles, required one", name, n);
    end
  endtask

  // Stimulus.
  initial begin
    int n, dur;
    int klist[10];
    klist = '{3, 5, 8, 9, 10, 10, 10, 11, 12, 30};
    RESET = 1'b1; ENABLE = 1'b1; CLR_FAIL = 1'b0;

    // Reset with the crystal running.
    repeat (3) @(negedge CLK);
    check("rst_sel", SEL_XTL, 0);
    check("rst_good", XTL_GOOD, 0);
    check("rst_fail", XTL_FAIL, 0);
    check("rst_meas", MEAS_VALID, 0);
    check("rst_count", EDGE_COUNT, 0);
    repeat (2) @(negedge CLK);
    RESET = 1'b0;

    // Lock latency from enable.
    n = 0;
    while (SEL_XTL !== 1'b1 && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("lock_latency", n, 201);
    repeat (250) @(negedge CLK);

    // Crystal stops right after a window end; CLR_FAIL coincides with the
    // failing window end, then is repeated one cycle later.
    wait_meas(200, "pre_fail_meas");
    xstop = 1'b1;
    repeat (W - 1) @(negedge CLK);
    CLR_FAIL = 1'b1;
    @(negedge CLK);
    check("fail_set_wins", XTL_FAIL, 1);
    check("fail_sel_drop", SEL_XTL, 0);
    @(negedge CLK);
    check("fail_cleared", XTL_FAIL, 0);
    CLR_FAIL = 1'b0;
    repeat (500) @(negedge CLK);

    // Recover and relock.
    xstop = 1'b0; xk = 10;
    wait_sel(800, "relock");

    // Disable at wcnt = 50 while locked.
    wait_meas(200, "pre_disable_meas");
    repeat (50) @(negedge CLK);
    ENABLE = 1'b0;
    @(negedge CLK);
    check("dis_sel", SEL_XTL, 0);
    check("dis_meas", MEAS_VALID, 0);
    check("dis_fail", XTL_FAIL, 0);
    repeat (20) @(negedge CLK);
    ENABLE = 1'b1;
    wait_sel(600, "relock_after_disable");

    // Out-of-range crystal (20 edges per window).
    xk = 5;
    repeat (700) @(negedge CLK);
    check("oor_sel", SEL_XTL, 0);
    check("oor_good", XTL_GOOD, 0);
    check("oor_fail", XTL_FAIL, 1);
    CLR_FAIL = 1'b1;
    @(negedge CLK);
    CLR_FAIL = 1'b0;

    // Mid-window reset.
    xk = 10;
    repeat (137) @(negedge CLK);
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
    repeat (300) @(negedge CLK);

    // Randomized segments.
    for (int s = 0; s < 20; s++) begin
      xk    = klist[$urandom_range(0, 9)];
      xstop = ($urandom_range(0, 9) == 0);
      dur   = $urandom_range(100, 500);
      for (int c = 0; c < dur; c++) begin
        @(negedge CLK);
        CLR_FAIL = ($urandom_range(0, 149) == 0);
        if ($urandom_range(0, 399) == 0) ENABLE = 1'b0;
        else if (!ENABLE && $urandom_range(0, 3) == 0) ENABLE = 1'b1;
      end
    end
    CLR_FAIL = 1'b0;
    ENABLE   = 1'b1;
    repeat (10) @(negedge CLK);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
